// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/address widths, their types and the
// loader state encoding used by the instruction-memory writer.
package cpu_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] inst_t;
  typedef logic [ADDR_W-1:0] iaddr_t;
  typedef logic [ADDR_W:0]   len_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master is the loader side, slave is the stream source / memory side.
interface imem_loader_if;
  import cpu_pkg::*;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       we;
  iaddr_t     waddr;
  inst_t      wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four consecutive stream bytes into a little-endian word and
// flags the transfer that completes it.
module byte_packer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] byte_data,
  output inst_t      word,
  output logic       last
);

  logic [1:0] lane;

  assign last = accept && (lane == 2'd3);

  // Lane wraps 3 -> 0 on its own, so the next word starts at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= 2'd0;
      word <= '0;
    end else if (clear) begin
      lane <= 2'd0;
    end else if (accept) begin
      word[{lane, 3'b000} +: 8] <= byte_data;
      lane                      <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: writes a byte stream as 32-bit words from
// address 0 and holds the CPU in reset until the whole program is in.
module imem_loader
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  len_t                 load_len,
  imem_loader_if.master        bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_hold,
  output len_t                 word_cnt
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RECV  = RECV;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0] state;
  logic [1:0] next_state;
  len_t       len_q;
  logic       len_ok;
  logic       accept_start;
  logic       accept;
  logic       last;
  logic       last_word;
  inst_t      word;

  assign len_ok         = (load_len != '0) && (load_len <= len_t'(MAX_WORDS));
  assign accept_start   = (state == ST_IDLE) && start && len_ok;
  assign bus.byte_ready = (state == ST_RECV);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign last_word      = (word_cnt + 1'b1) == len_q;
  assign bus.wdata      = word;

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept_start),
    .accept    (accept),
    .byte_data (bus.byte_data),
    .word      (word),
    .last      (last)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept_start) next_state = ST_RECV;
      ST_RECV:  if (last) next_state = ST_WRITE;
      ST_WRITE: next_state = last_word ? ST_DONE : ST_RECV;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so each one lines up
  // with the cycle that state is actually occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      word_cnt  <= '0;
      bus.waddr <= '0;
      bus.we    <= 1'b0;
      busy      <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state    <= next_state;
      bus.we   <= (next_state == ST_WRITE);
      busy     <= (next_state == ST_RECV) || (next_state == ST_WRITE);
      cpu_hold <= (next_state == ST_RECV) || (next_state == ST_WRITE);
      done     <= (next_state == ST_DONE);
      err      <= (state == ST_IDLE) && start && !len_ok;
      if (accept_start) begin
        len_q     <= load_len;
        word_cnt  <= '0;
        bus.waddr <= '0;
      end
      // The final write leaves waddr on the last address so it never wraps.
      if (state == ST_WRITE) begin
        word_cnt <= word_cnt + 1'b1;
        if (!last_word) bus.waddr <= bus.waddr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: a table of stream words plus
// hand-written sequences for lengths, full depth, reset and stray starts.
module tb_imem_loader;
  import cpu_pkg::*;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          gap;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  len_t load_len;
  logic busy, done, err, cpu_hold;
  len_t word_cnt;

  imem_loader_if bus ();

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_len (load_len),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int we_count = 0;
  int done_count = 0;
  int err_count = 0;
  logic [31:0] last_addr;
  logic [31:0] last_data;
  logic [31:0] mem_model [MAX_WORDS];
  int write_cnt [MAX_WORDS];
  vec_t vecs [3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory-side observer: records every write and pulse away from the edge.
  always @(negedge clk) begin
    if (bus.we) begin
      we_count++;
      last_addr = 32'(bus.waddr);
      last_data = bus.wdata;
      mem_model[bus.waddr] = bus.wdata;
      write_cnt[bus.waddr]++;
      checkOutput("ready_in_write", 32'(bus.byte_ready), 32'd0);
    end
    if (done) done_count++;
    if (err) err_count++;
  end

  task automatic clear_model();
    for (int i = 0; i < MAX_WORDS; i++) begin
      mem_model[i] = '0;
      write_cnt[i] = 0;
    end
  endtask

  task automatic start_load(input len_t n);
    start = 1'b1;
    load_len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    for (int n = 0; n < 50 && !bus.byte_ready; n++) @(negedge clk);
    checkOutput("ready_wait", 32'(bus.byte_ready), 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_we(input int prev);
    for (int n = 0; n < 20 && we_count == prev; n++) @(negedge clk);
    checkOutput("we_seen", 32'(we_count), 32'(prev + 1));
  endtask

  task automatic wait_done(input int prev);
    for (int n = 0; n < 20 && done_count == prev; n++) @(negedge clk);
    checkOutput("done_seen", 32'(done_count), 32'(prev + 1));
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    int prev;
    prev = we_count;
    send_byte(v.b0, v.gap);
    send_byte(v.b1, v.gap);
    send_byte(v.b2, v.gap);
    send_byte(v.b3, v.gap);
    wait_we(prev);
    checkOutput("vec_waddr", last_addr, v.exp_addr);
    checkOutput("vec_wdata", last_data, v.exp_data);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    checkOutput({tag, "_we"}, 32'(bus.we), 32'd0);
    checkOutput({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
    checkOutput({tag, "_wdata"}, bus.wdata, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_wcnt"}, 32'(word_cnt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prev_we, prev_done, prev_err, bad;

    vecs[0] = '{b0: 8'h04, b1: 8'h00, b2: 8'h00, b3: 8'h00, gap: 1, exp_addr: 32'd0, exp_data: 32'h0000_0004};
    vecs[1] = '{b0: 8'h04, b1: 8'h21, b2: 8'h00, b3: 8'h00, gap: 2, exp_addr: 32'd1, exp_data: 32'h0000_2104};
    vecs[2] = '{b0: 8'h00, b1: 8'h20, b2: 8'h08, b3: 8'h00, gap: 3, exp_addr: 32'd2, exp_data: 32'h0008_2000};

    rst = 1'b1;
    start = 1'b0;
    load_len = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    clear_model();
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single word with valid held high; exact we/done timing.
    $display("[TB] single word");
    start_load(9'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checkOutput("t1_we", 32'(bus.we), 32'd1);
    checkOutput("t1_waddr", 32'(bus.waddr), 32'd0);
    checkOutput("t1_wdata", bus.wdata, 32'h0000_0004);
    @(negedge clk);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_we_low", 32'(bus.we), 32'd0);
    checkOutput("t1_hold_low", 32'(cpu_hold), 32'd0);
    checkOutput("t1_wcnt", 32'(word_cnt), 32'd1);
    @(negedge clk);
    checkOutput("t1_done_low", 32'(done), 32'd0);

    // Three words from the table with gapped valid.
    $display("[TB] three words");
    prev_done = done_count;
    start_load(9'd3);
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);
    wait_done(prev_done);
    checkOutput("t2_wcnt", 32'(word_cnt), 32'd3);
    checkOutput("t2_waddr_final", 32'(bus.waddr), 32'd2);

    // Rejected lengths.
    $display("[TB] bad lengths");
    prev_we = we_count;
    prev_err = err_count;
    start_load(9'd0);
    checkOutput("t3_err0", 32'(err), 32'd1);
    checkOutput("t3_busy0", 32'(busy), 32'd0);
    checkOutput("t3_hold0", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    checkOutput("t3_err0_low", 32'(err), 32'd0);
    start_load(9'd257);
    checkOutput("t3_err257", 32'(err), 32'd1);
    checkOutput("t3_busy257", 32'(busy), 32'd0);
    checkOutput("t3_ready257", 32'(bus.byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t3_err_count", 32'(err_count), 32'(prev_err + 2));
    checkOutput("t3_no_we", 32'(we_count), 32'(prev_we));

    // Full depth, word i = i.
    $display("[TB] full depth");
    clear_model();
    prev_we = we_count;
    prev_done = done_count;
    start_load(9'd256);
    for (int i = 0; i < MAX_WORDS; i++) begin
      send_byte(8'(i), 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
    end
    wait_done(prev_done);
    bad = 0;
    for (int i = 0; i < MAX_WORDS; i++)
      if (mem_model[i] !== 32'(i) || write_cnt[i] != 1) bad++;
    checkOutput("t4_mem_bad", 32'(bad), 32'd0);
    checkOutput("t4_we_count", 32'(we_count), 32'(prev_we + 256));
    checkOutput("t4_last_addr", last_addr, 32'd255);
    checkOutput("t4_last_data", last_data, 32'd255);
    checkOutput("t4_waddr_hold", 32'(bus.waddr), 32'd255);
    checkOutput("t4_wcnt", 32'(word_cnt), 32'd256);
    repeat (3) @(negedge clk);
    checkOutput("t4_done_once", 32'(done_count), 32'(prev_done + 1));

    // Reset in the middle of word 1.
    $display("[TB] reset mid-load");
    start_load(9'd3);
    applyStimulus('{b0: 8'h11, b1: 8'h22, b2: 8'h33, b3: 8'h44, gap: 0, exp_addr: 32'd0, exp_data: 32'h4433_2211});
    prev_we = we_count;
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("t5");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t5_no_we", 32'(we_count), 32'(prev_we));
    prev_done = done_count;
    start_load(9'd1);
    applyStimulus('{b0: 8'hAA, b1: 8'hBB, b2: 8'hCC, b3: 8'hDD, gap: 0, exp_addr: 32'd0, exp_data: 32'hDDCC_BBAA});
    wait_done(prev_done);

    // Byte offered together with start, then a stray start during RECV.
    $display("[TB] stray start");
    prev_we = we_count;
    prev_err = err_count;
    prev_done = done_count;
    start = 1'b1;
    load_len = 9'd2;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hEE;
    @(negedge clk);
    start = 1'b0;
    bus.byte_valid = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    start = 1'b1;
    load_len = 9'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h03, 1);
    send_byte(8'h04, 0);
    wait_we(prev_we);
    checkOutput("t6_w0", last_data, 32'h0403_0201);
    applyStimulus('{b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12, gap: 0, exp_addr: 32'd1, exp_data: 32'h1234_5678});
    wait_done(prev_done);
    checkOutput("t6_wcnt", 32'(word_cnt), 32'd2);
    checkOutput("t6_no_err", 32'(err_count), 32'(prev_err));
    checkOutput("t6_we_count", 32'(we_count), 32'(prev_we + 2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
